// File: rtl/clb_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : clb_config_loader
// Description : Serial framed configuration loader for the CLB array. It
//               checks sync, address and parity, then commits a 27-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module clb_config_loader #(
    parameter int NUM_CLBS = 4,
    parameter int CFG_BITS = 27
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         bit_in,
    input  logic                         bit_valid,
    output logic                         bit_ready,
    input  logic                         cfg_abort,
    output logic [NUM_CLBS*CFG_BITS-1:0] cfg_word,
    output logic [NUM_CLBS-1:0]          cfg_loaded,
    output logic                         done,
    output logic                         err,
    output logic                         busy
);

    localparam logic [2:0] c_st_header  = 3'd0;
    localparam logic [2:0] c_st_payload = 3'd1;
    localparam logic [2:0] c_st_parity  = 3'd2;
    localparam logic [2:0] c_st_commit  = 3'd3;
    localparam logic [2:0] c_st_error   = 3'd4;

    localparam logic [4:0] c_hdr_last = 5'd7;
    localparam logic [4:0] c_pay_last = 5'(CFG_BITS - 1);

    logic [2:0]                   state_q, state_d;
    logic [4:0]                   cnt_q, cnt_d;
    logic [3:0]                   addr_q, addr_d;
    logic                         sync_ok_q, sync_ok_d;
    logic                         par_q, par_d;
    logic [CFG_BITS-1:0]          shadow_q, shadow_d;
    logic [NUM_CLBS*CFG_BITS-1:0] cfg_word_q, cfg_word_d;
    logic [NUM_CLBS-1:0]          cfg_loaded_q, cfg_loaded_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;

    logic                         w_accept;
    logic [3:0]                   w_addr_full;

    assign bit_ready   = (state_q == c_st_header) || (state_q == c_st_payload) ||
                         (state_q == c_st_parity);
    assign w_accept    = bit_valid & bit_ready;
    // h7 is the address MSB, so the full address is only known combinationally.
    assign w_addr_full = {bit_in, addr_q[2:0]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        sync_ok_d    = sync_ok_q;
        par_d        = par_q;
        shadow_d     = shadow_q;
        cfg_word_d   = cfg_word_q;
        cfg_loaded_d = cfg_loaded_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        if (cfg_abort) begin
            state_d = c_st_header;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                c_st_header: begin
                    if (w_accept) begin
                        cnt_d = cnt_q + 5'd1;
                        par_d = 1'b0;
                        // Sync pattern is 1,0,1,0: expected bit is the inverse of cnt LSB.
                        if (!cnt_q[2]) begin
                            sync_ok_d = ((cnt_q == 5'd0) ? 1'b1 : sync_ok_q) &
                                        (bit_in == ~cnt_q[0]);
                        end else begin
                            addr_d[cnt_q[1:0]] = bit_in;
                        end
                        if (cnt_q == c_hdr_last) begin
                            cnt_d = 5'd0;
                            if (!sync_ok_q || ({1'b0, w_addr_full} >= 5'(NUM_CLBS))) begin
                                state_d = c_st_error;
                            end else begin
                                state_d = c_st_payload;
                            end
                        end
                    end
                end
                c_st_payload: begin
                    if (w_accept) begin
                        shadow_d = {bit_in, shadow_q[CFG_BITS-1:1]};
                        par_d    = par_q ^ bit_in;
                        cnt_d    = cnt_q + 5'd1;
                        if (cnt_q == c_pay_last) begin
                            cnt_d   = 5'd0;
                            state_d = c_st_parity;
                        end
                    end
                end
                c_st_parity: begin
                    if (w_accept) begin
                        state_d = (bit_in == par_q) ? c_st_commit : c_st_error;
                    end
                end
                c_st_commit: begin
                    for (int i = 0; i < NUM_CLBS; i++) begin
                        if (addr_q == 4'(i)) begin
                            cfg_word_d[i*CFG_BITS +: CFG_BITS] = shadow_q;
                            cfg_loaded_d[i]                    = 1'b1;
                        end
                    end
                    done_d  = 1'b1;
                    cnt_d   = 5'd0;
                    state_d = c_st_header;
                end
                c_st_error: begin
                    err_d   = 1'b1;
                    cnt_d   = 5'd0;
                    state_d = c_st_header;
                end
                default: begin
                    cnt_d   = 5'd0;
                    state_d = c_st_header;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= c_st_header;
            cnt_q        <= 5'd0;
            addr_q       <= 4'd0;
            sync_ok_q    <= 1'b0;
            par_q        <= 1'b0;
            shadow_q     <= '0;
            cfg_word_q   <= '0;
            cfg_loaded_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            sync_ok_q    <= sync_ok_d;
            par_q        <= par_d;
            shadow_q     <= shadow_d;
            cfg_word_q   <= cfg_word_d;
            cfg_loaded_q <= cfg_loaded_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign cfg_word   = cfg_word_q;
    assign cfg_loaded = cfg_loaded_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = (state_q != c_st_header) || (cnt_q != 5'd0);

endmodule
`default_nettype wire

// File: tb/tb_clb_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_clb_config_loader
// Description : Self-checking bench for clb_config_loader with a frame-level
//               reference model and randomized framed stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clb_config_loader;

    localparam int N = 4;
    localparam int W = 27;

    logic           clk       = 1'b0;
    logic           reset     = 1'b1;
    logic           bit_in    = 1'b0;
    logic           bit_valid = 1'b0;
    logic           cfg_abort = 1'b0;
    logic           bit_ready;
    logic [N*W-1:0] cfg_word;
    logic [N-1:0]   cfg_loaded;
    logic           done;
    logic           err;
    logic           busy;

    always #5 clk = ~clk;

    clb_config_loader #(.NUM_CLBS(N), .CFG_BITS(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .cfg_abort  (cfg_abort),
        .cfg_word   (cfg_word),
        .cfg_loaded (cfg_loaded),
        .done       (done),
        .err        (err),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Frame-level model: accepted bits are collected in a queue and judged
    // when the header or the whole frame is complete.
    bit           m_bits[$];
    bit           m_stall  = 1'b0;
    bit           m_commit = 1'b0;
    bit           m_done   = 1'b0;
    bit           m_err    = 1'b0;
    bit           m_par;
    int           m_addr   = 0;
    logic [W-1:0] m_pay    = '0;
    logic [W-1:0] m_slice [N] = '{default: '0};
    logic [N-1:0] m_loaded = '0;

    function automatic logic [N*W-1:0] m_word();
        logic [N*W-1:0] w;
        for (int i = 0; i < N; i++) w[i*W +: W] = m_slice[i];
        return w;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_bits.delete();
            m_stall  = 1'b0;
            m_commit = 1'b0;
            m_done   = 1'b0;
            m_err    = 1'b0;
            m_loaded = '0;
            for (int i = 0; i < N; i++) m_slice[i] = '0;
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (cfg_abort) begin
                m_bits.delete();
                m_stall = 1'b0;
            end else if (m_stall) begin
                if (m_commit) begin
                    m_slice[m_addr]  = m_pay;
                    m_loaded[m_addr] = 1'b1;
                    m_done           = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
                m_stall = 1'b0;
                m_bits.delete();
            end else if (bit_valid) begin
                m_bits.push_back(bit_in);
                if (m_bits.size() == 8) begin
                    m_addr = m_bits[4] + 2 * m_bits[5] + 4 * m_bits[6] + 8 * m_bits[7];
                    if (!(m_bits[0] && !m_bits[1] && m_bits[2] && !m_bits[3]) || m_addr >= N) begin
                        m_stall  = 1'b1;
                        m_commit = 1'b0;
                    end
                end else if (m_bits.size() == 36) begin
                    m_par = 1'b0;
                    for (int k = 0; k < W; k++) begin
                        m_pay[k] = m_bits[8+k];
                        m_par    = m_par ^ m_bits[8+k];
                    end
                    m_stall  = 1'b1;
                    m_commit = (m_bits[35] == m_par);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("bit_ready",  bit_ready,  !m_stall);
        chk("busy",       busy,       m_stall || (m_bits.size() != 0));
        chk("done",       done,       m_done);
        chk("err",        err,        m_err);
        chk("cfg_loaded", cfg_loaded, m_loaded);
        chk("cfg_word",   cfg_word,   m_word());
    end

    // Offer one bit until it is accepted (valid && ready && no abort).
    task automatic send_bit(input bit b, input int gap_pct, input int abort_pm);
        bit rdy;
        bit taken = 1'b0;
        int guard = 0;
        while (!taken) begin
            @(negedge clk);
            rdy       = bit_ready;
            cfg_abort = ($urandom_range(999) < abort_pm);
            bit_valid = ($urandom_range(99) >= gap_pct);
            bit_in    = b;
            @(posedge clk);
            taken = bit_valid && rdy && !cfg_abort;
            guard++;
            if (guard > 200) begin
                chk("send_bit_timeout", guard, 0);
                taken = 1'b1;
            end
        end
    endtask

    task automatic send_header(input bit [3:0] sync, input int addr, input int gap);
        for (int k = 0; k < 4; k++) send_bit(sync[3-k], gap, 0);
        for (int k = 0; k < 4; k++) send_bit(addr[k], gap, 0);
    endtask

    task automatic send_frame(input int addr, input logic [W-1:0] pay, input bit bad_par,
                              input bit bad_sync, input int gap, input int abort_pm);
        bit f[36];
        f[0] = 1'b1; f[1] = bad_sync; f[2] = 1'b1; f[3] = 1'b0;
        for (int k = 0; k < 4; k++) f[4+k] = addr[k];
        for (int k = 0; k < W; k++) f[8+k] = pay[k];
        f[35] = (^pay) ^ bad_par;
        for (int k = 0; k < 36; k++) send_bit(f[k], gap, abort_pm);
    endtask

    // Idles the inputs and counts falling edges until the chosen pulse shows.
    task automatic wait_pulse(input bit want_err, output int lat);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            bit_valid = 1'b0;
            cfg_abort = 1'b0;
            if ((want_err ? err : done) === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    int           lat;
    logic [W-1:0] pay;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", bit_ready, 1);
        chk("rst_busy",  busy, 0);
        chk("rst_word",  cfg_word, 0);
        reset = 1'b0;

        // Good frame to CLB 2
        send_frame(2, 27'h5A5A5A5, 0, 0, 0, 0);
        wait_pulse(0, lat);
        chk("good_done_latency", lat, 2);
        chk("good_slice2", cfg_word[2*W +: W], 27'h5A5A5A5);
        chk("good_word",   cfg_word, 108'h5A5A5A5 << 54);
        chk("good_loaded", cfg_loaded, 4'b0100);

        // Same frame with a bad parity bit
        send_frame(2, 27'h5A5A5A5, 1, 0, 0, 0);
        wait_pulse(1, lat);
        chk("parity_err_latency", lat, 2);
        chk("parity_word_kept", cfg_word, 108'h5A5A5A5 << 54);
        chk("parity_loaded_kept", cfg_loaded, 4'b0100);
        send_frame(1, 27'h0123456, 0, 0, 0, 0);
        wait_pulse(0, lat);
        chk("after_parity_done", lat, 2);
        chk("after_parity_slice1", cfg_word[1*W +: W], 27'h0123456);

        // Bad sync, then resync on a clean frame
        send_header(4'b1000, 1, 0);
        wait_pulse(1, lat);
        chk("sync_err_latency", lat, 2);
        pay = W'($urandom);
        send_frame(3, pay, 0, 0, 0, 0);
        wait_pulse(0, lat);
        chk("resync_done", lat, 2);
        chk("resync_slice3", cfg_word[3*W +: W], pay);

        // Out-of-range address
        send_header(4'b1010, 5, 0);
        wait_pulse(1, lat);
        chk("addr_err_latency", lat, 2);
        chk("addr_loaded_kept", cfg_loaded, 4'b1110);

        // Abort on the cycle p10 is offered
        send_header(4'b1010, 0, 0);
        for (int k = 0; k < 10; k++) send_bit(k[0], 0, 0);
        @(negedge clk);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        cfg_abort = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        cfg_abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_no_done", done, 0);
        chk("abort_no_err", err, 0);
        send_frame(0, 27'h7FFFFFF, 0, 0, 0, 0);
        wait_pulse(0, lat);
        chk("ones_done", lat, 2);
        chk("ones_slice0", cfg_word[0 +: W], 27'h7FFFFFF);
        chk("ones_loaded", cfg_loaded, 4'b1111);

        // Random valid gaps, addr 3
        pay = W'($urandom);
        send_frame(3, pay, 0, 0, 40, 0);
        wait_pulse(0, lat);
        chk("gaps_done", lat, 2);
        chk("gaps_slice3", cfg_word[3*W +: W], pay);

        // Reset in the middle of a payload
        send_header(4'b1010, 1, 30);
        for (int k = 0; k < 5; k++) send_bit(1'b1, 30, 0);
        #2;
        bit_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chk("midrst_word",   cfg_word, 0);
        chk("midrst_loaded", cfg_loaded, 0);
        chk("midrst_ready",  bit_ready, 1);
        chk("midrst_busy",   busy, 0);
        chk("midrst_done",   done, 0);
        chk("midrst_err",    err, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Randomized frames: some bad sync, address, parity, and rare aborts
        for (int f = 0; f < 40; f++) begin
            send_frame($urandom_range(0, 5), W'($urandom),
                       ($urandom_range(4) == 0), ($urandom_range(7) == 0),
                       $urandom_range(0, 50), ($urandom_range(1) == 0) ? 0 : 5);
        end
        @(negedge clk);
        bit_valid = 1'b0;
        cfg_abort = 1'b0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clb_config_loader.md
# clb_config_loader

Serial configuration loader for the CLB array. It accepts a framed configuration bitstream one bit per handshake, checks sync, address and parity, and commits a 27-bit configuration word to the addressed CLB. That word holds the input, LUT, flip-flop and output fields. Registered per-CLB configuration outputs drive the CLB `*_configuration_word` inputs directly and stay stable between commits.

## Interface
Parameters:
- NUM_CLBS, 4: number of CLBs served; legal range 1..16.
- CFG_BITS, 27: configuration word width per CLB; fixed at 27.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- bit_in  in  1  serial configuration bit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  loader can accept a bit this cycle.
- cfg_abort  in  1  synchronous abort of the frame in progress.
- cfg_word  out  NUM_CLBS*27  slice i = bits [27*i+26 : 27*i]. Within a slice:
  - [5:0] input_configuration_word
  - [21:6] lut_configuration_word
  - [24:22] flip_flop_configuration_word
  - [26:25] output_configuration_word
- cfg_loaded  out  NUM_CLBS  sticky; bit i set once CLB i has been committed.
- done  out  1  one-cycle pulse: commit completed.
- err  out  1  one-cycle pulse: frame rejected.
- busy  out  1  a frame is partially received, or the loader is in COMMIT or ERROR.

## Operation
- A bit is accepted on a rising edge where bit_valid && bit_ready.
- Frame = 36 accepted bits, in arrival order:
  - h0..h7: h0..h3 must be 1,0,1,0 (sync); h4..h7 = target address, LSB first.
  - p0..p26: payload; p_k lands at slice bit k.
  - q: parity bit; must equal the XOR of p0..p26 (even parity).
- States:
  - HEADER (reset state): bit counter 0..7. On accepting h7:
    - sync mismatch, or address >= NUM_CLBS -> ERROR.
    - otherwise -> PAYLOAD.
  - PAYLOAD: shift payload into the shadow register, counter 0..26; after p26 -> PARITY.
  - PARITY: on accepting q, -> COMMIT if parity is correct, else -> ERROR.
  - COMMIT: one cycle with bit_ready=0. At the exiting edge:
    - shadow -> cfg_word slice[addr];
    - cfg_loaded[addr] <= 1;
    - done <= 1;
    - -> HEADER, counter cleared.
  - ERROR: one cycle with bit_ready=0. At the exiting edge: err <= 1, -> HEADER. cfg_word and cfg_loaded are unchanged.
- bit_ready = 1 in HEADER, PAYLOAD and PARITY; 0 in COMMIT and ERROR.
- cfg_abort, any state: at the next edge go to HEADER with counter 0, no done/err, shadow discarded.
  - Abort has priority over bit acceptance and over a pending commit in the same cycle.
- busy = (state != HEADER) || (header counter != 0).
- Other slices of cfg_word never change during a commit. Re-committing a slice overwrites it fully.
- Arithmetic: parity is a running XOR cleared at frame start. Counters are 5-bit and never wrap; each state exits at its terminal count.

## Timing
- Reset values: bit_ready=1, done=0, err=0, busy=0, cfg_word=0, cfg_loaded=0, state HEADER.
- Latency from the edge accepting q:
  - good frame: next cycle is COMMIT; the following edge updates cfg_word and asserts done. done and the new cfg_word are first visible together, 2 cycles after q is accepted.
  - parity failure: err is visible 2 cycles after q is accepted.
- Header error: err is visible 2 cycles after h7 is accepted.
- Back-to-back frames: the first bit of the next frame can be accepted in the cycle done is high. Minimum frame period = 37 cycles.
- bit_valid gaps stall counters indefinitely; there is no timeout.
- Reset asserted mid-frame clears everything immediately, including committed cfg_word.

## Test plan
- Good frame, addr 2, payload 27'h5A5A5A5, q=0, bit_valid continuous -> done pulse 2 cycles after q; slice 2 = 27'h5A5A5A5; cfg_loaded = 4'b0100; other slices 0.
- Same frame with q=1 -> err pulse 2 cycles after q; cfg_word and cfg_loaded unchanged; the next good frame commits normally.
- Sync 1,0,0,0, then addr 1 -> err 2 cycles after h7; the remaining bits of the stream are treated as a new header (verify resync with a following clean frame).
- NUM_CLBS=4, addr 5 -> err after h7; no slice written.
- Abort asserted on the cycle p10 is offered -> p10 not consumed, busy=0 next cycle, no done/err. Then a full frame to addr 0 with payload 27'h7FFFFFF, q=1 -> slice 0 all ones.
- Random bit_valid gaps during a frame to addr 3 -> same result as the continuous case. Then reset asserted mid-payload of a second frame -> all outputs at reset values within the same cycle.
